// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues synchronous imem reads, buffers
// returned words in a 2-entry queue and hands them to decode via valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        hlt,
  output logic        halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc_q, pend_pc_q;
  logic        pend_q, squash_q;
  logic [1:0]  count;
  logic [31:0] q_insn [2];
  logic [31:0] q_pc   [2];

  logic        pop, hlt_pop, redir, push, slot;
  logic [2:0]  occ;

  assign instr_valid = (count != 2'd0);
  assign instr       = instr_valid ? q_insn[0] : NOP_INSN;
  assign instr_pc    = instr_valid ? q_pc[0]   : 32'h0;
  assign imem_addr   = pc_q;
  assign halted      = (state == HALT);

  always_comb begin
    state_next = state;
    hlt_pop    = 1'b0;
    redir      = 1'b0;
    pop        = instr_valid & instr_ready;
    if (state == RUN) begin
      hlt_pop = hlt & pop;
      redir   = redirect & ~(hlt & pop);
      if (hlt & pop) state_next = HALT;
    end
    // occupancy the queue would reach if this cycle's request were issued
    occ      = {1'b0, count} + {2'b00, pend_q} - {2'b00, pop};
    imem_req = ~reset & (state == RUN) & ~redirect & ~hlt_pop & (occ < 3'd2);
    push     = pend_q & ~squash_q & (state == RUN) & ~redirect & ~hlt_pop;
    slot     = (count == 2'd2) | ((count == 2'd1) & ~pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'h0;
      squash_q  <= 1'b0;
      count     <= 2'd0;
      q_insn[0] <= 32'h0;
      q_insn[1] <= 32'h0;
      q_pc[0]   <= 32'h0;
      q_pc[1]   <= 32'h0;
    end else begin
      state    <= state_next;
      pend_q   <= imem_req;
      squash_q <= squash_q | hlt_pop;
      if (imem_req) pend_pc_q <= pc_q;

      if (redir)         pc_q <= redirect_target & ~32'h3;
      else if (imem_req) pc_q <= pc_q + 32'd4;

      if (hlt_pop || redir) count <= 2'd0;
      else                  count <= count + {1'b0, push} - {1'b0, pop};

      if (pop) begin
        q_insn[0] <= q_insn[1];
        q_pc[0]   <= q_pc[1];
      end
      if (push) begin
        q_insn[slot] <= imem_rdata;
        q_pc[slot]   <= pend_pc_q;
      end
    end
  end

  // the issue rule must keep a push from ever landing on a full queue
  assert property (@(posedge clk) disable iff (reset) !(push && count == 2'd2 && !pop));

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the decode/controller stage. It owns the program counter and issues word reads to a synchronous instruction memory. It buffers returned instruction words in a 2-entry queue and presents them to decode with a valid/ready handshake. It also applies PC redirects (taken branch or jump, as resolved by the controller's `pcsrc`/`jump`) and the `hlt` stop.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INSN`, default 32'h0000_0013: value driven on `instr` while the queue is empty.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `imem_req`, output, 1: read request this cycle (combinational).
- `imem_addr`, output, 32: read address; always equals `pc_q`; bits [1:0] are always 0.
- `imem_rdata`, input, 32: read data, valid exactly one cycle after the cycle in which `imem_req` was 1.
- `instr`, output, 32: instruction word at the queue head.
- `instr_pc`, output, 32: address of `instr`.
- `instr_valid`, output, 1: queue is non-empty.
- `instr_ready`, input, 1: decode accepts the head. Pop = `instr_valid & instr_ready`.
- `redirect`, input, 1: taken branch or jump; flush and refetch.
- `redirect_target`, input, 32: new PC; bits [1:0] are forced to 0 internally.
- `hlt`, input, 1: the instruction being popped this cycle is a halt.
- `halted`, output, 1: fetch is permanently stopped until reset.

## Operation

- State: `pc_q` (32), `pend_q` (read in flight), `pend_pc_q`, `squash_q` (drop the in-flight response), queue (2 entries of {insn, pc}, `count` 0..2), FSM {RUN, HALT}.
- Issue rule: `imem_req = (state==RUN) & !redirect & !(hlt & pop) & (count + pend_q - pop < 2)`.
- When a request issues: `pend_pc_q <= pc_q` and `pc_q <= pc_q + 4`, modulo 2^32 (wraps 32'hFFFF_FFFC to 0).
- Response cycle (`pend_q`=1): if `squash_q`=0 and there is no redirect, halt or reset this cycle, push {`imem_rdata`, `pend_pc_q`}. Otherwise discard it.
- Push and pop in the same cycle are both legal; `count` is unchanged. Push into a full queue cannot occur because the issue rule prevents it. This is checked by an assertion.
- Redirect (RUN):
  - queue cleared (`count`<=0);
  - `pc_q <= {redirect_target[31:2], 2'b00}`;
  - any response arriving this cycle is dropped;
  - no request this cycle;
  - fetch resumes at the target on the next cycle.
  - The same-cycle pop still completes toward decode.
- Halt: `hlt & pop` in RUN:
  - state becomes HALT;
  - queue is flushed;
  - the in-flight response is squashed;
  - `halted` becomes 1;
  - `imem_req` stays 0.
- HALT is left only by reset. `redirect` is ignored in HALT.
- Simultaneous `hlt & pop` and `redirect`: halt wins; `pc_q` is not updated.
- `redirect` while the queue is empty and nothing is in flight: only `pc_q` is loaded.
- Empty queue: `instr = NOP_INSN`, `instr_pc` = 0, `instr_valid` = 0.

## Timing

- Reset values, held asynchronously while `reset`=1:
  - `pc_q = RESET_PC`, `pend_q` = 0, `squash_q` = 0, `count` = 0, state RUN;
  - `instr_valid` = 0, `instr = NOP_INSN`, `instr_pc` = 0, `halted` = 0;
  - `imem_req` = 0 while reset is asserted.
- Cycle T0 is the first cycle after reset deasserts:
  - T0: `imem_req`=1 with `imem_addr = RESET_PC`.
  - T1: data returns.
  - T2: `instr_valid`=1 with `instr_pc = RESET_PC`.
- Fetch latency is 2 cycles from request to `instr_valid`.
- With `instr_ready` held at 1, throughput is 1 instruction per cycle with no bubbles.
- Redirect in cycle R: the request for the target issues in R+1, and the target instruction becomes valid in R+3. Redirect penalty is 2 bubbles.
- Reset asserted mid-operation: all state clears immediately. A response arriving after reset deasserts is not pushed, because `pend_q` was cleared.
- Decode backpressure: with `instr_ready`=0, at most 2 entries are queued and no request issues. Requests resume in the cycle in which `pop` makes room.

## Test plan

- Reset release, `RESET_PC`=0x100, ready=1, memory returns `addr ^ 0xA5A5_0000` -> `instr_pc` sequence 0x100, 0x104, 0x108 on consecutive cycles starting at T2, each `instr` matching.
- Ready=0 for 5 cycles starting at T2 -> `count` saturates at 2 and `imem_req`=0. Raising ready -> 0x100, 0x104, 0x108 delivered in order with no loss or duplication.
- Redirect to 0x203 with one in-flight response and 2 entries queued -> queue flushed and the stale word never appears. Next `instr_pc` = 0x200, valid 2 cycles after the R+1 request.
- Pop of an entry with `hlt`=1 and `redirect`=1 in the same cycle -> `halted`=1 next cycle. After that, `instr_valid`=0 and `imem_req`=0 forever, and `pc_q` is unchanged.
- `pc_q` = 0xFFFF_FFFC -> the next fetch address is 0x0000_0000.
- Reset asserted 1 cycle after a request issues -> no push occurs. After release, fetch restarts at `RESET_PC` with T0/T2 timing.
